// File: rtl/saper_pkg.sv
// -----------------------------------------------------------------------------
// saper_pkg
// Shared definitions for the minesweeper board logic: level codes, board side
// constants, board size helpers and the status scanner FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package saper_pkg;

    // Level codes as driven on the 2-bit `level` bus.
    typedef enum logic [1:0] {
        NONE   = 2'b00,
        EASY   = 2'b01,
        MEDIUM = 2'b10,
        HARD   = 2'b11
    } level_t;

    // Board side lengths, sized to the 5-bit coordinate buses.
    localparam logic [4:0] SIDE_EASY   = 5'd8;
    localparam logic [4:0] SIDE_MEDIUM = 5'd10;
    localparam logic [4:0] SIDE_HARD   = 5'd16;

    localparam int COORD_W = 5;
    localparam int CNT_W   = 9;

    // Status scanner FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_DONE = 2'b10
    } scan_state_t;

    // Side length of the board for a level; 0 when no game is selected.
    function automatic logic [4:0] board_side(input level_t lv);
        case (lv)
            EASY:    return SIDE_EASY;
            MEDIUM:  return SIDE_MEDIUM;
            HARD:    return SIDE_HARD;
            default: return 5'd0;
        endcase
    endfunction

    // Number of fields on the board (side squared); 256 needs all 9 bits.
    function automatic logic [CNT_W-1:0] board_area(input level_t lv);
        case (lv)
            EASY:    return 9'd64;
            MEDIUM:  return 9'd100;
            HARD:    return 9'd256;
            default: return 9'd0;
        endcase
    endfunction

endpackage

// File: rtl/board_field_select.sv
// -----------------------------------------------------------------------------
// board_field_select
// Combinational field lookup: returns the mine and defused bits of field
// [y][x] from the arrays that belong to the given level. Coordinates outside
// the board (or level NONE) return 0 for both bits.
//
// Ports:
//   level               in  level_t   board whose arrays are addressed
//   x, y                in  5         0-based field coordinates
//   mine_arr_*          in  packed    mine maps, index [y][x], 1 = mine
//   defuse_arr_*        in  packed    defuse maps, index [y][x], 1 = defused
//   mine, defused       out 1         selected field bits
// -----------------------------------------------------------------------------
module board_field_select
    import saper_pkg::*;
(
    input  level_t             level,
    input  logic [4:0]         x,
    input  logic [4:0]         y,
    input  logic [7:0][7:0]    mine_arr_easy,
    input  logic [9:0][9:0]    mine_arr_medium,
    input  logic [15:0][15:0]  mine_arr_hard,
    input  logic [7:0][7:0]    defuse_arr_easy,
    input  logic [9:0][9:0]    defuse_arr_medium,
    input  logic [15:0][15:0]  defuse_arr_hard,
    output logic               mine,
    output logic               defused
);

    always_comb begin
        mine    = 1'b0;
        defused = 1'b0;
        case (level)
            EASY: begin
                if (x < SIDE_EASY && y < SIDE_EASY) begin
                    mine    = mine_arr_easy[y[2:0]][x[2:0]];
                    defused = defuse_arr_easy[y[2:0]][x[2:0]];
                end
            end
            MEDIUM: begin
                if (x < SIDE_MEDIUM && y < SIDE_MEDIUM) begin
                    mine    = mine_arr_medium[y[3:0]][x[3:0]];
                    defused = defuse_arr_medium[y[3:0]][x[3:0]];
                end
            end
            HARD: begin
                if (x < SIDE_HARD && y < SIDE_HARD) begin
                    mine    = mine_arr_hard[y[3:0]][x[3:0]];
                    defused = defuse_arr_hard[y[3:0]][x[3:0]];
                end
            end
            default: begin
                mine    = 1'b0;
                defused = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/board_status_scanner.sv
// -----------------------------------------------------------------------------
// board_status_scanner
// Walks every field of the selected board once (raster order, one field per
// clock), streams each field out on registered fld_* outputs and reduces the
// board to defused/mine counts plus mine_hit and win flags.
//
// Ports:
//   clk, rst            in  1     clock, asynchronous active-high reset
//   level               in  2     board select, latched when a start is taken
//   start               in  1     scan request
//   mine_arr_*          in  pk    mine maps [y][x], read live during the scan
//   defuse_arr_*        in  pk    defuse maps [y][x], read live during scan
//   busy                out 1     scan in progress
//   done                out 1     one-cycle pulse, results valid from here
//   fld_valid           out 1     qualifies fld_x/fld_y/fld_defused/fld_mine
//   fld_x, fld_y        out 5     coordinates of the streamed field
//   fld_defused,fld_mine out 1    bits of the streamed field
//   defused_cnt         out 9     defused fields without a mine
//   mine_cnt            out 9     mines on the board
//   mine_hit            out 1     some field is both defused and mined
//   win                 out 1     all non-mine fields defused, no hit
//
// Handshake: start is a request with no acknowledge other than busy. It is
// taken only while the FSM is IDLE (busy low, or the done cycle); a start
// seen while busy is dropped, never queued. done is a single-cycle pulse and
// the result outputs hold until the next done.
// -----------------------------------------------------------------------------
module board_status_scanner
    import saper_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         level,
    input  logic               start,
    input  logic [7:0][7:0]    mine_arr_easy,
    input  logic [9:0][9:0]    mine_arr_medium,
    input  logic [15:0][15:0]  mine_arr_hard,
    input  logic [7:0][7:0]    defuse_arr_easy,
    input  logic [9:0][9:0]    defuse_arr_medium,
    input  logic [15:0][15:0]  defuse_arr_hard,
    output logic               busy,
    output logic               done,
    output logic               fld_valid,
    output logic [4:0]         fld_x,
    output logic [4:0]         fld_y,
    output logic               fld_defused,
    output logic               fld_mine,
    output logic [8:0]         defused_cnt,
    output logic [8:0]         mine_cnt,
    output logic               mine_hit,
    output logic               win
);

    // FSM state is kept in a single named register so checkers can bind to it.
    scan_state_t       state;
    scan_state_t       state_next;

    level_t            level_q;
    logic [4:0]        x;
    logic [4:0]        y;
    logic [CNT_W-1:0]  acc_def;
    logic [CNT_W-1:0]  acc_mine;
    logic              acc_hit;

    logic              sel_mine;
    logic              sel_defused;
    logic [4:0]        side_m1;
    logic              last_field;

    board_field_select u_sel (
        .level             (level_q),
        .x                 (x),
        .y                 (y),
        .mine_arr_easy     (mine_arr_easy),
        .mine_arr_medium   (mine_arr_medium),
        .mine_arr_hard     (mine_arr_hard),
        .defuse_arr_easy   (defuse_arr_easy),
        .defuse_arr_medium (defuse_arr_medium),
        .defuse_arr_hard   (defuse_arr_hard),
        .mine              (sel_mine),
        .defused           (sel_defused)
    );

    // side-1 of the latched board; only used in SCAN, where side is nonzero.
    assign side_m1    = board_side(level_q) - 5'd1;
    assign last_field = (x == side_m1) && (y == side_m1);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. A NONE level has no fields, so it skips SCAN.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (level_t'(level) == NONE) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (last_field) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: coordinates, accumulators and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q     <= NONE;
            x           <= 5'd0;
            y           <= 5'd0;
            acc_def     <= '0;
            acc_mine    <= '0;
            acc_hit     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fld_valid   <= 1'b0;
            fld_x       <= 5'd0;
            fld_y       <= 5'd0;
            fld_defused <= 1'b0;
            fld_mine    <= 1'b0;
            defused_cnt <= '0;
            mine_cnt    <= '0;
            mine_hit    <= 1'b0;
            win         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    fld_valid <= 1'b0;
                    if (start) begin
                        level_q  <= level_t'(level);
                        x        <= 5'd0;
                        y        <= 5'd0;
                        acc_def  <= '0;
                        acc_mine <= '0;
                        acc_hit  <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                S_SCAN: begin
                    fld_valid   <= 1'b1;
                    fld_x       <= x;
                    fld_y       <= y;
                    fld_defused <= sel_defused;
                    fld_mine    <= sel_mine;
                    if (sel_mine) begin
                        acc_mine <= acc_mine + 9'd1;
                    end
                    if (sel_defused && !sel_mine) begin
                        acc_def <= acc_def + 9'd1;
                    end
                    if (sel_defused && sel_mine) begin
                        acc_hit <= 1'b1;
                    end
                    // Coordinates stop on the last field so they never leave
                    // the board.
                    if (!last_field) begin
                        if (x == side_m1) begin
                            x <= 5'd0;
                            y <= y + 5'd1;
                        end else begin
                            x <= x + 5'd1;
                        end
                    end
                end
                S_DONE: begin
                    fld_valid   <= 1'b0;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    defused_cnt <= acc_def;
                    mine_cnt    <= acc_mine;
                    mine_hit    <= acc_hit;
                    // A board with no mines is never a win.
                    win         <= !acc_hit && (acc_mine != '0) &&
                                   (acc_def == (board_area(level_q) - acc_mine));
                end
                default: begin
                    fld_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_status_scanner.sv
// -----------------------------------------------------------------------------
// tb_board_status_scanner
// Directed bench for board_status_scanner: scans hand-built boards and compares
// latency, streamed fields and final verdicts against hand-computed values.
// -----------------------------------------------------------------------------
module tb_board_status_scanner;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [1:0]        level;
    logic              start;
    logic [7:0][7:0]   me, de;
    logic [9:0][9:0]   mm, dm;
    logic [15:0][15:0] mh, dh;
    logic              busy, done, fld_valid, fld_defused, fld_mine, mine_hit, win;
    logic [4:0]        fld_x, fld_y;
    logic [8:0]        defused_cnt, mine_cnt;

    board_status_scanner dut (
        .clk               (clk),
        .rst               (rst),
        .level             (level),
        .start             (start),
        .mine_arr_easy     (me),
        .mine_arr_medium   (mm),
        .mine_arr_hard     (mh),
        .defuse_arr_easy   (de),
        .defuse_arr_medium (dm),
        .defuse_arr_hard   (dh),
        .busy              (busy),
        .done              (done),
        .fld_valid         (fld_valid),
        .fld_x             (fld_x),
        .fld_y             (fld_y),
        .fld_defused       (fld_defused),
        .fld_mine          (fld_mine),
        .defused_cnt       (defused_cnt),
        .mine_cnt          (mine_cnt),
        .mine_hit          (mine_hit),
        .win               (win)
    );

    // ---------------- scoreboard ----------------
    // Each entry: {y[4:0], x[4:0], mine, defused} of the next expected field.
    logic [11:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // Mid-scan stimulus hooks (cycle numbers after the start edge; -1 = off).
    int r1 = -1, r2 = -1, lc_at = -1;
    logic [1:0] lc_lv = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // ---------------- driver helpers ----------------
    task automatic clear_arrays();
        me = '0; de = '0; mm = '0; dm = '0; mh = '0; dh = '0;
    endtask

    task automatic fill_q(input logic [1:0] lv);
        int side;
        logic m, d;
        side = (lv == 2'b01) ? 8 : (lv == 2'b10) ? 10 : (lv == 2'b11) ? 16 : 0;
        exp_q.delete();
        for (int yy = 0; yy < side; yy++) begin
            for (int xx = 0; xx < side; xx++) begin
                if (lv == 2'b01) begin
                    m = me[3'(yy)][3'(xx)]; d = de[3'(yy)][3'(xx)];
                end else if (lv == 2'b10) begin
                    m = mm[4'(yy)][4'(xx)]; d = dm[4'(yy)][4'(xx)];
                end else begin
                    m = mh[4'(yy)][4'(xx)]; d = dh[4'(yy)][4'(xx)];
                end
                exp_q.push_back({5'(yy), 5'(xx), m, d});
            end
        end
    endtask

    // Issues a start with the given level at the current time (just after a
    // posedge), follows the scan to done and checks stream and results.
    task automatic do_scan(input string tag, input logic [1:0] lv, input int exp_lat,
                           input int e_mine, input int e_def, input bit e_hit, input bit e_win);
        int lat;
        logic [11:0] e;
        fill_q(lv);
        level = lv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_e0"}, busy, 1);
        lat = 0;
        while (lat < 400) begin
            start = (lat == r1 || lat == r2);
            if (lat == lc_at) level = lc_lv;
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (fld_valid) begin
                if (exp_q.size() == 0) begin
                    check({tag, "_extra_fld"}, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check({tag, "_fld"}, {20'd0, fld_y, fld_x, fld_mine, fld_defused}, {20'd0, e});
                end
            end
            if (done) break;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_fields_left"}, exp_q.size(), 0);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_mine_cnt"}, mine_cnt, e_mine);
        check({tag, "_defused_cnt"}, defused_cnt, e_def);
        check({tag, "_mine_hit"}, mine_hit, e_hit);
        check({tag, "_win"}, win, e_win);
        r1 = -1; r2 = -1; lc_at = -1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int dcount;
        level = 2'b00;
        start = 1'b0;
        clear_arrays();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_a", {busy, done, fld_valid, fld_x, fld_y, fld_defused, fld_mine}, 0);
        check("rst_b", {defused_cnt, mine_cnt, mine_hit, win}, 0);

        // Easy, empty board: 64 fields in raster order, latency 65.
        do_scan("easy_empty", 2'b01, 65, 0, 0, 1'b0, 1'b0);

        // Easy, no mines but every field defused: never a win.
        de = '1;
        do_scan("easy_nomine", 2'b01, 65, 0, 64, 1'b0, 1'b0);

        // Easy, 10 mines at raster 0,6,..,54; all 54 others defused: win.
        clear_arrays();
        for (int k = 0; k < 10; k++) me[3'((6 * k) / 8)][3'((6 * k) % 8)] = 1'b1;
        de = ~me;
        do_scan("easy_win", 2'b01, 65, 10, 54, 1'b0, 1'b1);

        // Hard: mines at raster 0..38 plus (x=3,y=5); (3,5) also defused;
        // raster 100..199 defused -> 40 mines, 100 defused, hit, no win.
        for (int k = 0; k < 39; k++) mh[4'(k / 16)][4'(k % 16)] = 1'b1;
        mh[5][3] = 1'b1;
        dh[5][3] = 1'b1;
        for (int k = 100; k < 200; k++) dh[4'(k / 16)][4'(k % 16)] = 1'b1;
        do_scan("hard_hit", 2'b11, 257, 40, 100, 1'b1, 1'b0);

        // Medium: mines at raster 0..4, defused raster 10..29; start re-pulsed
        // at cycles 20 and 50, level switched to easy at cycle 30.
        for (int k = 0; k < 5; k++) mm[4'(k / 10)][4'(k % 10)] = 1'b1;
        for (int k = 10; k < 30; k++) dm[4'(k / 10)][4'(k % 10)] = 1'b1;
        r1 = 20; r2 = 50; lc_at = 30; lc_lv = 2'b01;
        do_scan("med_restart", 2'b10, 101, 5, 20, 1'b0, 1'b0);
        // Start in the done cycle is accepted.
        check("med_done_cycle", done, 1);
        do_scan("med_again", 2'b10, 101, 5, 20, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("med_idle_busy", busy, 0);
        check("med_idle_done", done, 0);

        // Reset 30 cycles into a hard scan: everything clears, no done.
        level = 2'b11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_a", {busy, done, fld_valid, fld_x, fld_y, fld_defused, fld_mine}, 0);
        check("midrst_b", {defused_cnt, mine_cnt, mine_hit, win}, 0);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done) dcount++;
        end
        check("midrst_no_done", dcount, 0);
        check("midrst_busy", busy, 0);
        do_scan("after_rst", 2'b01, 65, 10, 54, 1'b0, 1'b1);

        // No game: done after 1 cycle, no fields, counts cleared.
        do_scan("level_none", 2'b00, 1, 0, 0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
